// File: rtl/parity_stream_gc.sv
// parity_stream_gc: streaming parity generator/checker.
// Each accepted word gets a generated parity bit and a mismatch flag.
// Words pass through a head/skid pair so in_ready can stay registered.
// Error statistics are a sticky flag and a saturating counter.
module parity_stream_gc #(
  parameter int DATA_W = 8,
  parameter int CNT_W  = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              odd_mode,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_parity,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic              out_parity,
  output logic              out_error,
  output logic              err_sticky,
  output logic [CNT_W-1:0]  err_count,
  input  logic              clr_err
);

  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  // Reduction XOR of a data word (even parity of the bits themselves).
  function automatic logic parity_f(input logic [DATA_W-1:0] d);
    return ^d;
  endfunction

  // Head (output) register and skid register, current and next.
  logic              head_valid_r, head_valid_s;
  logic [DATA_W-1:0] head_data_r,  head_data_s;
  logic              head_par_r,   head_par_s;
  logic              head_err_r,   head_err_s;
  logic              skid_valid_r, skid_valid_s;
  logic [DATA_W-1:0] skid_data_r,  skid_data_s;
  logic              skid_par_r,   skid_par_s;
  logic              skid_err_r,   skid_err_s;
  logic              in_ready_r;
  logic              sticky_r,     sticky_s;
  logic [CNT_W-1:0]  cnt_r,        cnt_s;

  logic accept_s;
  logic send_s;
  logic new_par_s;
  logic new_err_s;

  // Handshake qualifiers and parity of the word being offered.
  always_comb begin
    accept_s  = in_valid & in_ready_r;
    send_s    = head_valid_r & out_ready;
    new_par_s = parity_f(in_data) ^ odd_mode;
    new_err_s = in_parity ^ new_par_s;
  end

  // Next state of the head/skid pair; at most one of accept-into-skid or
  // skid-to-head can happen since accept needs the skid to be empty.
  always_comb begin
    head_valid_s = head_valid_r;
    head_data_s  = head_data_r;
    head_par_s   = head_par_r;
    head_err_s   = head_err_r;
    skid_valid_s = skid_valid_r;
    skid_data_s  = skid_data_r;
    skid_par_s   = skid_par_r;
    skid_err_s   = skid_err_r;
    if (send_s && skid_valid_r) begin
      head_valid_s = 1'b1;
      head_data_s  = skid_data_r;
      head_par_s   = skid_par_r;
      head_err_s   = skid_err_r;
      skid_valid_s = 1'b0;
    end else if (accept_s && (!head_valid_r || send_s)) begin
      head_valid_s = 1'b1;
      head_data_s  = in_data;
      head_par_s   = new_par_s;
      head_err_s   = new_err_s;
    end else if (accept_s) begin
      skid_valid_s = 1'b1;
      skid_data_s  = in_data;
      skid_par_s   = new_par_s;
      skid_err_s   = new_err_s;
    end else if (send_s) begin
      head_valid_s = 1'b0;
    end else begin
      head_valid_s = head_valid_r;
    end
  end

  // Error statistics; a new error word wins over a simultaneous clear.
  always_comb begin
    sticky_s = sticky_r;
    cnt_s    = cnt_r;
    if (accept_s && new_err_s) begin
      sticky_s = 1'b1;
      if (clr_err) begin
        cnt_s = CNT_W'(1);
      end else if (cnt_r == CNT_MAX) begin
        cnt_s = cnt_r;
      end else begin
        cnt_s = cnt_r + CNT_W'(1);
      end
    end else if (clr_err) begin
      sticky_s = 1'b0;
      cnt_s    = '0;
    end else begin
      sticky_s = sticky_r;
    end
  end

  // State registers; in_ready mirrors the next skid occupancy.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      head_valid_r <= 1'b0;
      head_data_r  <= '0;
      head_par_r   <= 1'b0;
      head_err_r   <= 1'b0;
      skid_valid_r <= 1'b0;
      skid_data_r  <= '0;
      skid_par_r   <= 1'b0;
      skid_err_r   <= 1'b0;
      in_ready_r   <= 1'b1;
      sticky_r     <= 1'b0;
      cnt_r        <= '0;
    end else begin
      head_valid_r <= head_valid_s;
      head_data_r  <= head_data_s;
      head_par_r   <= head_par_s;
      head_err_r   <= head_err_s;
      skid_valid_r <= skid_valid_s;
      skid_data_r  <= skid_data_s;
      skid_par_r   <= skid_par_s;
      skid_err_r   <= skid_err_s;
      in_ready_r   <= ~skid_valid_s;
      sticky_r     <= sticky_s;
      cnt_r        <= cnt_s;
    end
  end

  assign in_ready   = in_ready_r;
  assign out_valid  = head_valid_r;
  assign out_data   = head_data_r;
  assign out_parity = head_par_r;
  assign out_error  = head_err_r;
  assign err_sticky = sticky_r;
  assign err_count  = cnt_r;

endmodule

// File: tb/tb_parity_stream_gc.sv
// Testbench for parity_stream_gc: directed steps followed by random traffic,
// checked against a queue-based reference model of the stream.
module tb_parity_stream_gc;

  localparam int DW = 8;
  localparam int CW = 2;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          odd_mode = 1'b0;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [DW-1:0] in_data = '0;
  logic          in_parity = 1'b0;
  logic          out_valid;
  logic          out_ready = 1'b0;
  logic [DW-1:0] out_data;
  logic          out_parity;
  logic          out_error;
  logic          err_sticky;
  logic [CW-1:0] err_count;
  logic          clr_err = 1'b0;

  parity_stream_gc #(.DATA_W(DW), .CNT_W(CW)) dut (
    .clk(clk), .rst_n(rst_n), .odd_mode(odd_mode),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .in_parity(in_parity), .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .out_parity(out_parity), .out_error(out_error),
    .err_sticky(err_sticky), .err_count(err_count), .clr_err(clr_err)
  );

  always #5 clk = ~clk;

  // Reference model: words in flight as {data, parity, error}.
  logic [DW+1:0] mq[$];
  int            m_cnt;
  bit            m_sticky;
  bit            m_ready;
  int            n_vec;
  int            n_err;
  bit            last_acc;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_all();
    logic [DW+1:0] h;
    chk("in_ready", 32'(in_ready), 32'(m_ready));
    chk("out_valid", 32'(out_valid), 32'(mq.size() > 0));
    chk("err_sticky", 32'(err_sticky), 32'(m_sticky));
    chk("err_count", 32'(err_count), 32'(m_cnt));
    if (mq.size() > 0) begin
      h = mq[0];
      chk("out_data", 32'(out_data), 32'(h[DW+1:2]));
      chk("out_parity", 32'(out_parity), 32'(h[1]));
      chk("out_error", 32'(out_error), 32'(h[0]));
    end
  endtask

  // One clock: predict from pre-edge inputs, advance, then compare.
  task automatic step();
    bit acc, snd, gen, er;
    acc = in_valid && m_ready;
    snd = (mq.size() > 0) && out_ready;
    gen = bit'($countones(in_data) % 2) ^ odd_mode;
    er  = in_parity ^ gen;
    @(posedge clk);
    #1;
    if (snd) void'(mq.pop_front());
    if (acc) mq.push_back({in_data, gen, er});
    if (acc && er) begin
      m_sticky = 1'b1;
      m_cnt = clr_err ? 1 : ((m_cnt + 1 > 3) ? 3 : m_cnt + 1);
    end else if (clr_err) begin
      m_sticky = 1'b0;
      m_cnt = 0;
    end
    m_ready = (mq.size() < 2);
    last_acc = acc;
    check_all();
  endtask

  task automatic offer(input logic [7:0] d, input logic p);
    in_valid = 1'b1;
    in_data = d;
    in_parity = p;
    step();
  endtask

  task automatic model_reset();
    mq.delete();
    m_cnt = 0;
    m_sticky = 1'b0;
    m_ready = 1'b1;
  endtask

  initial begin
    n_vec = 0;
    n_err = 0;
    model_reset();
    #12;
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_out_data", 32'(out_data), 32'd0);
    chk("rst_out_parity", 32'(out_parity), 32'd0);
    chk("rst_out_error", 32'(out_error), 32'd0);
    chk("rst_err_count", 32'(err_count), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // Even mode, streaming.
    out_ready = 1'b1;
    odd_mode = 1'b0;
    offer(8'hA5, 1'b0);
    chk("even_a5_par", 32'(out_parity), 32'd0);
    offer(8'h01, 1'b0);
    chk("even_01_par", 32'(out_parity), 32'd1);
    chk("even_01_err", 32'(out_error), 32'd1);
    chk("even_01_cnt", 32'(err_count), 32'd1);

    // Odd mode.
    odd_mode = 1'b1;
    offer(8'hA5, 1'b1);
    chk("odd_a5_err", 32'(out_error), 32'd0);
    offer(8'hFF, 1'b0);
    chk("odd_ff_par", 32'(out_parity), 32'd1);
    chk("odd_ff_err", 32'(out_error), 32'd1);
    in_valid = 1'b0;
    odd_mode = 1'b0;
    step();

    // Backpressure: third word must be held off.
    out_ready = 1'b0;
    offer(8'h11, 1'b0);
    offer(8'h22, 1'b0);
    chk("bp_in_ready_low", 32'(in_ready), 32'd0);
    offer(8'h33, 1'b0);
    offer(8'h33, 1'b0);
    chk("bp_hold_data", 32'(out_data), 32'h11);
    out_ready = 1'b1;
    step();
    chk("bp_release", 32'(in_ready), 32'd1);
    chk("bp_second", 32'(out_data), 32'h22);
    step();
    chk("bp_third", 32'(out_data), 32'h33);
    in_valid = 1'b0;
    step();

    // Saturation of the 2-bit counter.
    clr_err = 1'b1;
    step();
    clr_err = 1'b0;
    for (int i = 0; i < 5; i++) offer(8'(i * 3 + 1), 1'b0 ^ bit'(($countones(8'(i * 3 + 1)) % 2) == 0));
    chk("sat_cnt", 32'(err_count), 32'd3);
    in_valid = 1'b0;
    step();
    chk("sat_hold", 32'(err_count), 32'd3);

    // Clear alone, then clear colliding with an error word.
    clr_err = 1'b1;
    step();
    chk("clr_cnt", 32'(err_count), 32'd0);
    chk("clr_sticky", 32'(err_sticky), 32'd0);
    offer(8'h01, 1'b0);
    clr_err = 1'b0;
    chk("clr_err_cnt", 32'(err_count), 32'd1);
    chk("clr_err_sticky", 32'(err_sticky), 32'd1);
    in_valid = 1'b0;
    step();

    // Random traffic honouring the hold rule while stalled.
    last_acc = 1'b1;
    for (int i = 0; i < 400; i++) begin
      if (!(in_valid && !last_acc)) begin
        in_valid  = ($urandom_range(0, 3) != 0);
        in_data   = 8'($urandom);
        in_parity = 1'($urandom);
        odd_mode  = 1'($urandom);
      end
      out_ready = ($urandom_range(0, 2) != 0);
      clr_err   = ($urandom_range(0, 15) == 0);
      step();
    end
    clr_err = 1'b0;

    // Asynchronous reset with two words buffered.
    out_ready = 1'b0;
    in_valid = 1'b0;
    step();
    while (mq.size() > 0) begin
      out_ready = 1'b1;
      step();
    end
    out_ready = 1'b0;
    offer(8'h5A, 1'b1);
    offer(8'h3C, 1'b1);
    in_valid = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    model_reset();
    chk("mid_rst_out_valid", 32'(out_valid), 32'd0);
    chk("mid_rst_in_ready", 32'(in_ready), 32'd1);
    chk("mid_rst_err_count", 32'(err_count), 32'd0);
    #3;
    rst_n = 1'b1;
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) step();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/parity_stream_gc.md
# parity_stream_gc

Parametrised, streaming parity generator and checker with registered valid/ready handshakes on both sides. For each accepted word it computes the parity for the word and checks it against the parity bit supplied with the word, in either even or odd mode. It carries the word, generated parity and error flag downstream through a two-entry skid buffer, and keeps a sticky error flag and a saturating error counter. It sits between a data source and a consumer on any byte/word link that needs parity protection.

## Interface
Parameters:
- DATA_W, 8, data word width in bits (≥1)
- CNT_W, 8, error counter width in bits (≥1)

Ports:
- clk  input  1  single clock; all logic is rising-edge triggered
- rst_n  input  1  reset; asynchronous assert, active-low
- odd_mode  input  1  0 = even parity, 1 = odd parity; sampled per word at acceptance
- in_valid  input  1  upstream word valid
- in_ready  output  1  block can accept a word; registered
- in_data  input  DATA_W  upstream word
- in_parity  input  1  parity bit received with in_data
- out_valid  output  1  downstream word valid
- out_ready  input  1  downstream can take a word
- out_data  output  DATA_W  word, unmodified
- out_parity  output  1  generated parity for out_data
- out_error  output  1  1 = received parity mismatched for this word
- err_sticky  output  1  set on any accepted error word; held until cleared
- err_count  output  CNT_W  number of accepted error words, saturating
- clr_err  input  1  synchronous clear of err_sticky and err_count

## Operation
- Accept: in_valid && in_ready at a rising edge. Send: out_valid && out_ready at a rising edge.
- Generated parity: gen = (XOR of all in_data bits) XOR odd_mode.
- Error: err = in_parity XOR gen.
- gen and err are computed at acceptance and stored with the word. Changing odd_mode later has no effect on buffered words.
- Storage is an output register (head) plus one skid register.
  - On accept with head empty, or head being sent with the skid empty: the word goes to head.
  - On accept with head full and not sent: the word goes to skid.
  - On send with the skid full: skid moves to head, and skid becomes empty.
- in_ready = NOT skid_valid, registered. No combinational path from out_ready to in_ready.
- Words leave in strict acceptance order. None are dropped or duplicated.
- Error statistics update only on an accepted word with err = 1:
  - err_sticky is set to 1.
  - err_count increments, saturating at 2^CNT_W−1 with no wrap.
- clr_err = 1: err_sticky ← 0 and err_count ← 0.
- clr_err together with an accepted error word: the result is err_sticky = 1 and err_count = 1, so the new event is never lost.
- in_valid while in_ready = 0: ignored, with no state change. Upstream must hold the word.

## Timing
- Reset values: in_ready = 1, out_valid = 0, out_data = 0, out_parity = 0, out_error = 0, err_sticky = 0, err_count = 0. Skid is empty.
- Reset asserted mid-operation: all buffered words are discarded immediately (asynchronously) and the outputs take their reset values.
- Latency: a word accepted at edge N appears with out_valid = 1 after edge N, provided head was empty or sent at N.
- Throughput: one word per cycle when out_ready is held at 1.
- Backpressure with out_ready = 0:
  - The first accept fills head; the second fills skid.
  - in_ready drops to 0 after the edge that fills skid.
- Release: after the edge where skid moves to head, in_ready = 1.
- The output holds stable (out_data, out_parity, out_error unchanged, out_valid = 1) while out_valid && !out_ready.
- err_sticky and err_count reflect a word's error after the edge at which that word is accepted, not when it is sent.

## Test plan
- Reset: drive rst_n = 0 mid-stream with 2 words buffered → out_valid = 0, in_ready = 1, err_count = 0 immediately; no stale word appears after release.
- Even mode, DATA_W = 8, out_ready = 1:
  - in_data = 0xA5, in_parity = 0 → next cycle out_data = 0xA5, out_parity = 0, out_error = 0.
  - in_data = 0x01, in_parity = 0 → out_parity = 1, out_error = 1, err_count = 1, err_sticky = 1.
- Odd mode: in_data = 0xA5, in_parity = 1 → out_parity = 1, out_error = 0. Then 0xFF with in_parity = 0 → out_parity = 1, out_error = 1.
- Backpressure: out_ready = 0, offer words 0x11, 0x22, 0x33 back-to-back.
  - 0x11 and 0x22 are accepted; in_ready = 0 from the third cycle and 0x33 is held.
  - Raise out_ready → outputs in order 0x11, 0x22, 0x33, with in_ready back to 1 once skid drains.
- Saturation: CNT_W = 2, five error words → err_count = 3 and stays at 3.
- Clear: pulse clr_err alone → err_count = 0, err_sticky = 0. Pulse clr_err in the same cycle as an error word is accepted → err_count = 1, err_sticky = 1.
